// File: rtl/pwm_generator.sv
// pwm_generator: per-channel PWM output stage with period-boundary double-buffered edge times
module pwm_generator #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cycle [DEPTH],
  input  logic [WIDTH-1:0] rise  [DEPTH],
  input  logic [WIDTH-1:0] fall  [DEPTH],
  input  logic             din_valid,
  input  logic             sync,
  output logic [DEPTH-1:0] pwm_out
);
  for (genvar g = 0; g < DEPTH; g++) begin : g_ch
    logic [WIDTH-1:0] t, pend_rise, pend_fall, act_rise, act_fall;
    logic pend_vld, en, wrap, apply, level, q;
    // period boundary detection and waveform level from the current count and active edges
    always_comb begin
      en = cycle[g] >= WIDTH'(2);
      wrap = sync | (t >= cycle[g] - 1'b1);
      apply = en & wrap & pend_vld;
      level = act_rise < act_fall ? (t >= act_rise) & (t < act_fall) :
              act_rise > act_fall ? (t >= act_rise) | (t < act_fall) : 1'b0;
    end
    // counter, pending/active edge buffers and registered drive; new data beats the apply clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        t <= '0;
        pend_rise <= '0;
        pend_fall <= '0;
        pend_vld <= 1'b0;
        act_rise <= '0;
        act_fall <= '0;
        q <= 1'b0;
      end else begin
        t <= en && !wrap ? t + 1'b1 : '0;
        q <= en & level;
        pend_vld <= din_valid | (pend_vld & ~apply);
        if (din_valid) begin
          pend_rise <= rise[g];
          pend_fall <= fall[g];
        end
        if (apply) begin
          act_rise <= pend_rise;
          act_fall <= pend_fall;
        end
      end
    end
    assign pwm_out[g] = q;
  end
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed scenario checks of the PWM output stage on three channels
module tb_pwm_generator;
  localparam int WIDTH = 13;
  localparam int DEPTH = 3;
  logic clk = 1'b0;
  logic rst_n;
  logic [WIDTH-1:0] cycle [DEPTH];
  logic [WIDTH-1:0] rise  [DEPTH];
  logic [WIDTH-1:0] fall  [DEPTH];
  logic din_valid, sync;
  logic [DEPTH-1:0] pwm_out;
  int checks = 0;
  int errors = 0;
  string s0, s1, s2;

  pwm_generator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cycle(cycle), .rise(rise), .fall(fall),
    .din_valid(din_valid), .sync(sync), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic pulse_din(input int r, input int f);
    for (int i = 0; i < DEPTH; i++) begin
      rise[i] = WIDTH'(r);
      fall[i] = WIDTH'(f);
    end
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic collect(input int n, output string a0, output string a1, output string a2);
    a0 = ""; a1 = ""; a2 = "";
    for (int i = 0; i < n; i++) begin
      a0 = $sformatf("%s%0d", a0, pwm_out[0]);
      a1 = $sformatf("%s%0d", a1, pwm_out[1]);
      a2 = $sformatf("%s%0d", a2, pwm_out[2]);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_out got %b want 000", pwm_out);
    end
    rst_n = 1'b1;
    collect(10, s0, s1, s2);
    checks++;
    if (s0 != "0000000000") begin
      errors++;
      $display("FAIL reset_idle got %s want 0000000000", s0);
    end
  endtask

  task automatic test_basic();
    pulse_din(2, 5);
    pulse_sync();
    collect(20, s0, s1, s2);
    checks++;
    if (s0 != "00011100000001110000") begin
      errors++;
      $display("FAIL basic_pulse got %s want 00011100000001110000", s0);
    end
  endtask

  task automatic test_wrapped();
    pulse_din(8, 3);
    pulse_sync();
    collect(20, s0, s1, s2);
    checks++;
    if (s0 != "01110000011111000001") begin
      errors++;
      $display("FAIL wrapped_pulse got %s want 01110000011111000001", s0);
    end
    pulse_din(4, 4);
    pulse_sync();
    collect(20, s0, s1, s2);
    checks++;
    if (s0 != "10000000000000000000") begin
      errors++;
      $display("FAIL zero_duty got %s want 10000000000000000000", s0);
    end
  endtask

  task automatic test_glitch_free();
    pulse_din(2, 5);
    pulse_sync();
    collect(4, s0, s1, s2);
    checks++;
    if (s0 != "0001") begin
      errors++;
      $display("FAIL glitch_setup got %s want 0001", s0);
    end
    pulse_din(6, 9);
    collect(15, s0, s1, s2);
    checks++;
    if (s0 != "100000000000111") begin
      errors++;
      $display("FAIL glitch_update got %s want 100000000000111", s0);
    end
  endtask

  task automatic test_simultaneous();
    pulse_sync();
    pulse_din(1, 4);
    repeat (8) @(negedge clk);
    pulse_din(5, 7);
    collect(20, s0, s1, s2);
    checks++;
    if (s0 != "00111000000000001100") begin
      errors++;
      $display("FAIL din_on_wrap got %s want 00111000000000001100", s0);
    end
  endtask

  task automatic test_back_to_back();
    pulse_din(0, 2);
    pulse_din(3, 8);
    collect(20, s0, s1, s2);
    checks++;
    if (s0 != "00001100000011111000") begin
      errors++;
      $display("FAIL back_to_back got %s want 00001100000011111000", s0);
    end
  endtask

  task automatic test_independence();
    pulse_din(4, 4);
    pulse_sync();
    pulse_din(1, 3);
    collect(20, s0, s1, s2);
    checks++;
    if (s0 != "00000000000110000000") begin
      errors++;
      $display("FAIL indep_ch0 got %s want 00000000000110000000", s0);
    end
    checks++;
    if (s1 != "00000000110000011000") begin
      errors++;
      $display("FAIL indep_ch1 got %s want 00000000110000011000", s1);
    end
    checks++;
    if (s2 != "00000000000000000000") begin
      errors++;
      $display("FAIL indep_ch2 got %s want 00000000000000000000", s2);
    end
    pulse_sync();
    collect(14, s0, s1, s2);
    checks++;
    if (s0 != "10110000000011") begin
      errors++;
      $display("FAIL sync_ch0 got %s want 10110000000011", s0);
    end
    checks++;
    if (s1 != "00110000011000") begin
      errors++;
      $display("FAIL sync_ch1 got %s want 00110000011000", s1);
    end
  endtask

  task automatic test_mid_reset();
    pulse_din(2, 5);
    pulse_sync();
    collect(4, s0, s1, s2);
    checks++;
    if (s0 != "0001" || pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got %s/%b want 0001/1", s0, pwm_out[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got %b want 000", pwm_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    collect(20, s0, s1, s2);
    checks++;
    if (s0 != "00000000000000000000" || s1 != "00000000000000000000") begin
      errors++;
      $display("FAIL post_reset got %s/%s want all zero", s0, s1);
    end
  endtask

  initial begin
    cycle[0] = 13'd10;
    cycle[1] = 13'd7;
    cycle[2] = 13'd1;
    for (int i = 0; i < DEPTH; i++) begin
      rise[i] = '0;
      fall[i] = '0;
    end
    din_valid = 1'b0;
    sync = 1'b0;
    test_reset();
    test_basic();
    test_wrapped();
    test_glitch_free();
    test_simultaneous();
    test_back_to_back();
    test_independence();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_generator.md
# pwm_generator

Per-transducer PWM output stage that consumes the folded rise/fall edge times produced by the PWM preconditioner. Each of DEPTH channels runs its own time counter modulo its ultrasound period CYCLE[i], double-buffers newly computed edge times, and applies them only at that channel's period boundary, so no channel ever emits a torn pulse. Sits between the preconditioner output (RISE/FALL/DOUT_VALID) and the transducer drive pins.

## Interface
- WIDTH, 13, bit width of cycle, time, rise and fall values
- DEPTH, 249, number of transducer channels
- CLK  in  1  sole clock; all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- CYCLE[DEPTH]  in  WIDTH  per-channel period in CLK ticks; quasi-static
- RISE[DEPTH]  in  WIDTH  new rise times, valid only with DIN_VALID
- FALL[DEPTH]  in  WIDTH  new fall times, valid only with DIN_VALID
- DIN_VALID  in  1  single-cycle strobe; RISE/FALL are complete and stable
- SYNC  in  1  single-cycle strobe; restarts every channel's time counter
- PWM_OUT[DEPTH]  out  1  registered drive signal per channel

## Operation
- Per-channel state:
  - t[i]: WIDTH-bit time counter
  - pend_rise[i], pend_fall[i]: pending edge registers
  - pend_vld[i]: pending flag
  - act_rise[i], act_fall[i]: active edge registers
- Reset (RST_N low, asynchronous): clear all t, pending, active and pend_vld to 0, and drive PWM_OUT to 0. All state holds while reset is asserted. Normal operation starts on the first CLK edge after RST_N rises.
- Channel disable: a channel with CYCLE[i] < 2 is disabled. It holds t[i]=0 and PWM_OUT[i]=0, and keeps its pending and active registers.
- Counter update for each enabled channel:
  - wrap[i] = SYNC or (t[i] >= CYCLE[i]-1)
  - t[i] <= wrap[i] ? 0 : t[i]+1
  - Use >= so that a CYCLE reduced below the current t wraps on the next edge.
- Capture: on DIN_VALID, every channel loads pend_* from RISE/FALL and sets pend_vld.
- Apply: on an edge where wrap[i] and pend_vld[i] are both true, load act_* from pend_* (their values before the edge) and clear pend_vld[i].
- Simultaneous DIN_VALID and wrap on the same edge:
  - act_* receives the old pending values if pend_vld was set; otherwise it is unchanged.
  - pend_* receives the new data.
  - pend_vld ends at 1, because set beats clear.
- Back-to-back DIN_VALID before a wrap: the last data wins. Intermediate data is never applied.
- Waveform, evaluated on the pre-edge t and act values:
  - If act_rise < act_fall: out = (t >= act_rise) and (t < act_fall).
  - If act_rise > act_fall: out = (t >= act_rise) or (t < act_fall), a pulse wrapping through 0.
  - If act_rise == act_fall: out = 0 (duty zero).
- The block does no range checking. Upstream guarantees act_rise and act_fall < CYCLE[i]. Out-of-range values are compared as-is.

## Timing
- PWM_OUT[i] is registered: the value after edge n equals f(t[i], act[i]) as they stood before edge n. Latency from counter value to pin is 1 CLK.
- From DIN_VALID to the waveform change: new edges take effect on the first wrap edge at or after the edge following DIN_VALID. The first sample using them is t=0 of the next period, appearing on PWM_OUT one CLK later.
- SYNC:
  - All enabled counters read 0 after the SYNC edge, regardless of their phase.
  - Any pending data is applied on that same edge.
  - If SYNC coincides with a natural wrap, only one restart occurs.
- Steady state: PWM_OUT[i] has period exactly CYCLE[i] CLK and high time (act_fall - act_rise) mod CYCLE[i].
- No backpressure: the block accepts DIN_VALID on any cycle, including consecutive cycles.

## Test plan
- Reset mid-operation: run CYCLE=10, rise=2, fall=5, then assert RST_N low asynchronously between edges. PWM_OUT drops to 0 immediately and t=0. After release with no DIN_VALID, PWM_OUT stays 0 because act is 0/0.
- Basic pulse: CYCLE=10, SYNC, then DIN_VALID with rise=2, fall=5. After the next wrap, PWM_OUT is high for exactly 3 CLK per 10-CLK period, rising 3 CLK after the registered t=0 sample (t=2 plus 1 CLK latency).
- Wrapped pulse: CYCLE=10, rise=8, fall=3. PWM_OUT is high for 5 CLK spanning the boundary (t=8,9,0,1,2). With rise=fall=4, PWM_OUT stays constantly 0.
- Glitch-free update: while a channel sits at t=4 with rise=2, fall=5, pulse DIN_VALID with rise=6, fall=9. The current period completes with the old pulse (high at t=2..4), and the next period is high at t=6..8.
- Simultaneous events:
  - DIN_VALID A, then DIN_VALID B on the same edge as a wrap: A becomes active, B stays pending and applies at the following wrap.
  - DIN_VALID C then D back-to-back before any wrap: only D is ever output.
- Per-channel independence: ch0 CYCLE=10, ch1 CYCLE=7, ch2 CYCLE=1. Each of ch0 and ch1 applies a common DIN_VALID at its own wrap, with periods 10 and 7. ch2 stays 0. A SYNC realigns ch0 and ch1 so both read t=0 on the same cycle.
